// File: rtl/rs232_pkg.sv
// Shared receiver definitions: FSM states, oversampling ratio, vote points, frame size.
// Combinational helpers only; no latency or backpressure.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int OSR       = 16;
  localparam int SCNT_W    = $clog2(OSR);
  localparam int SAMPLE_A  = 7;
  localparam int SAMPLE_B  = 8;
  localparam int SAMPLE_C  = 9;
  localparam int DATA_BITS = 8;

  // Clocks per 1/16 bit, rounded to nearest and never below one.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + baud * (OSR / 2)) / (baud * OSR);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Oversampling tick divider (1 tick = 1/16 bit), restartable by i_clr.
// Tick is combinational from the counter; no backpressure.
module rs232_baud_tick #(
  parameter int ClockFreq = 50000000,
  parameter int BaudFast  = 115200,
  parameter int BaudSlow  = 19200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_fsel,
  output logic o_tick
);
  import rs232_pkg::*;

  localparam int DIV_FAST = calc_div(ClockFreq, BaudFast);
  localparam int DIV_SLOW = calc_div(ClockFreq, BaudSlow);
  localparam int DIV_MAX  = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int CNT_W    = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  assign w_last = i_fsel ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);
  assign o_tick = !i_clr && (r_cnt == w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == w_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rs232_rx_os.sv
// 16x oversampling 8N1 receiver with majority vote, framing-error and sticky overrun flags.
// rdy rises 1 clk after the stop-bit vote; held byte waits for done, later bytes overrun.
module rs232_rx_os #(
  parameter int ClockFreq = 50000000,
  parameter int BaudFast  = 115200,
  parameter int BaudSlow  = 19200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fsel,
  input  logic       rxd,
  input  logic       done,
  output logic [7:0] data_out,
  output logic       rdy,
  output logic       ferr,
  output logic       ovr
);
  import rs232_pkg::*;

  logic              r_sync1, r_rxs, r_rxs_d;
  logic              r_fsel;
  state_t            r_state;
  logic [SCNT_W-1:0] r_scnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_s7, r_s8;
  logic              r_dlv, r_dlv_stop;
  logic [7:0]        r_data;
  logic              r_rdy, r_ferr, r_ovr;

  logic w_start, w_tick, w_vote, w_at_vote, w_bit_end;

  assign w_start   = (r_state == IDLE) && !r_rxs && r_rxs_d;
  assign w_vote    = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);
  assign w_at_vote = w_tick && (r_scnt == SCNT_W'(SAMPLE_C));
  assign w_bit_end = w_tick && (r_scnt == SCNT_W'(OSR - 1));

  rs232_baud_tick #(
    .ClockFreq(ClockFreq),
    .BaudFast (BaudFast),
    .BaudSlow (BaudSlow)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start),
    .i_fsel(r_fsel),
    .o_tick(w_tick)
  );

  // Preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fsel     <= 1'b0;
      r_scnt     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_s7       <= 1'b0;
      r_s8       <= 1'b0;
      r_dlv      <= 1'b0;
      r_dlv_stop <= 1'b0;
    end else begin
      r_dlv <= 1'b0;
      if (w_tick && (r_state != IDLE)) begin
        r_scnt <= r_scnt + 1'b1;
        if (r_scnt == SCNT_W'(SAMPLE_A)) r_s7 <= r_rxs;
        if (r_scnt == SCNT_W'(SAMPLE_B)) r_s8 <= r_rxs;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= START;
            r_scnt  <= '0;
            r_fsel  <= fsel;
            r_bit   <= '0;
          end
        end
        START: begin
          if (w_at_vote && w_vote) begin
            r_state <= IDLE;
          end else if (w_bit_end) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_at_vote) r_shift <= {w_vote, r_shift[7:1]};
          if (w_bit_end) begin
            if (r_bit == 3'(DATA_BITS - 1)) r_state <= STOP;
            else r_bit <= r_bit + 1'b1;
          end
        end
        STOP: begin
          if (w_at_vote) begin
            r_dlv      <= 1'b1;
            r_dlv_stop <= w_vote;
            r_state    <= w_vote ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (r_rxs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A done in the delivery cycle frees the slot, so the new byte is taken without overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rdy  <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else if (r_dlv) begin
      if (!r_rdy || done) begin
        r_data <= r_shift;
        r_ferr <= ~r_dlv_stop;
        r_rdy  <= 1'b1;
        if (done) r_ovr <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (done && r_rdy) begin
      r_rdy <= 1'b0;
      r_ovr <= 1'b0;
    end
  end

  assign data_out = r_data;
  assign rdy      = r_rdy;
  assign ferr     = r_ferr;
  assign ovr      = r_ovr;

endmodule

// File: tb/tb_rs232_rx_os.sv
// Bench for rs232_rx_os: frame table plus hand sequences, byte scoreboard on delivery events.
module tb_rs232_rx_os;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fsel = 1'b1;
  logic       rxd = 1'b1;
  logic       done = 1'b0;
  logic [7:0] data_out;
  logic       rdy, ferr, ovr;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } sb_item_t;
  sb_item_t sb_q[$];

  typedef struct {
    logic       fsel;
    logic [7:0] data;
    logic       stop;
    int         noise_pos;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  rs232_rx_os #(
    .ClockFreq(3200000),
    .BaudFast (100000),
    .BaudSlow (20000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fsel    (fsel),
    .rxd     (rxd),
    .done    (done),
    .data_out(data_out),
    .rdy     (rdy),
    .ferr    (ferr),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard: a delivery is rdy rising, or the held byte/flag changing while rdy stays high.
  logic       m_prev_rdy = 1'b0;
  logic [7:0] m_prev_data = 8'h00;
  logic       m_prev_ferr = 1'b0;
  initial begin
    sb_item_t exp_item;
    forever begin
      @(negedge clk);
      if (rst_n && rdy && (!m_prev_rdy || data_out !== m_prev_data || ferr !== m_prev_ferr)) begin
        if (sb_q.size() == 0) begin
          fail("sb_unexpected_delivery");
        end else begin
          exp_item = sb_q.pop_front();
          check("sb_data", {24'h0, data_out}, {24'h0, exp_item.data});
          check("sb_ferr", {31'h0, ferr}, {31'h0, exp_item.ferr});
        end
      end
      m_prev_rdy  = rdy;
      m_prev_data = data_out;
      m_prev_ferr = ferr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; every bit lasts 16*div clocks. noise_pos flips one sample of that frame slot.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int div, input int noise_pos);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      if (i == noise_pos) begin
        repeat (85) @(negedge clk);
        rxd = ~frame[i];
        repeat (10) @(negedge clk);
        rxd = frame[i];
        repeat (16 * div - 95) @(negedge clk);
      end else if (i == 9 && !stop) begin
        repeat (48 * div) @(negedge clk);
      end else begin
        repeat (16 * div) @(negedge clk);
      end
    end
    rxd = 1'b1;
    repeat (16 * div) @(negedge clk);
  endtask

  task automatic wait_rdy(input int budget);
    int n;
    n = 0;
    while (!rdy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rdy_within_budget", {31'h0, rdy}, 32'h1);
  endtask

  task automatic ack();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("ack_rdy_clear", {31'h0, rdy}, 32'h0);
    check("ack_ovr_clear", {31'h0, ovr}, 32'h0);
  endtask

  task automatic push(input logic [7:0] d, input logic f);
    sb_item_t it;
    it.data = d;
    it.ferr = f;
    sb_q.push_back(it);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b1, -1, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'h55, 1'b0, -1, 8'h55, 1'b1};
    vecs[2] = '{1'b0, 8'hF0, 1'b1,  4, 8'hF0, 1'b0};
    vecs[3] = '{1'b0, 8'hC3, 1'b1, -1, 8'hC3, 1'b0};
    vecs[4] = '{1'b1, 8'h00, 1'b1, -1, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_data", {24'h0, data_out}, 32'h0);
    check("reset_rdy", {31'h0, rdy}, 32'h0);
    check("reset_ferr", {31'h0, ferr}, 32'h0);
    check("reset_ovr", {31'h0, ovr}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) begin
      fsel = vecs[i].fsel;
      push(vecs[i].exp_data, vecs[i].exp_ferr);
      send_byte(vecs[i].data, vecs[i].stop, vecs[i].fsel ? 2 : 10, vecs[i].noise_pos);
      wait_rdy(2000);
      check($sformatf("vec%0d_data", i), {24'h0, data_out}, {24'h0, vecs[i].exp_data});
      check($sformatf("vec%0d_ferr", i), {31'h0, ferr}, {31'h0, vecs[i].exp_ferr});
      check($sformatf("vec%0d_ovr", i), {31'h0, ovr}, 32'h0);
      ack();
    end

    // Short low glitch must be rejected as a false start.
    fsel = 1'b1;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_rdy", {31'h0, rdy}, 32'h0);
    push(8'h3C, 1'b0);
    send_byte(8'h3C, 1'b1, 2, -1);
    wait_rdy(2000);
    check("glitch_next_data", {24'h0, data_out}, 32'h3C);
    ack();

    // Overrun: second byte lost while first is pending.
    push(8'h11, 1'b0);
    send_byte(8'h11, 1'b1, 2, -1);
    wait_rdy(2000);
    send_byte(8'h22, 1'b1, 2, -1);
    check("ovr_data_kept", {24'h0, data_out}, 32'h11);
    check("ovr_set", {31'h0, ovr}, 32'h1);
    check("ovr_rdy_held", {31'h0, rdy}, 32'h1);
    ack();

    // done in the exact delivery cycle: edge E0 + 4 + 154*div after the start-bit drive.
    push(8'h11, 1'b0);
    send_byte(8'h11, 1'b1, 2, -1);
    wait_rdy(2000);
    push(8'h22, 1'b0);
    fork
      send_byte(8'h22, 1'b1, 2, -1);
      begin
        repeat (3 + 154 * 2) @(posedge clk);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("same_cycle_data", {24'h0, data_out}, 32'h22);
        check("same_cycle_rdy", {31'h0, rdy}, 32'h1);
        check("same_cycle_ovr", {31'h0, ovr}, 32'h0);
      end
    join
    ack();

    // Reset mid-frame with a byte pending and a frame in flight.
    push(8'h7E, 1'b0);
    send_byte(8'h7E, 1'b1, 2, -1);
    wait_rdy(2000);
    rxd = 1'b0;
    repeat (5 * 32) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_data", {24'h0, data_out}, 32'h0);
    check("midreset_rdy", {31'h0, rdy}, 32'h0);
    check("midreset_ferr", {31'h0, ferr}, 32'h0);
    check("midreset_ovr", {31'h0, ovr}, 32'h0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * 32) @(negedge clk);
    check("postreset_no_rdy", {31'h0, rdy}, 32'h0);
    push(8'h5A, 1'b0);
    send_byte(8'h5A, 1'b1, 2, -1);
    wait_rdy(2000);
    check("postreset_data", {24'h0, data_out}, 32'h5A);
    ack();

    repeat (10) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
